// File: rtl/mips_mult_unit.sv
// Multi-cycle shift-add MULT/MULTU unit producing {hi,lo} with start/busy/done.
// Define MULT_EARLY_EXIT_EN to leave RUN once the multiplier register empties.
module mips_mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               neg;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   mplier_nxt;
   logic [CW-1:0]      cnt_nxt;
   logic               last;

   // Two's-complement magnitude; the most negative value maps onto itself.
   always_comb begin
      mag_a = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
      mag_b = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
   end

   always_comb begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mplier_nxt = mplier >> 1;
      cnt_nxt    = cnt - CW'(1);
`ifdef MULT_EARLY_EXIT_EN
      last       = (cnt_nxt == '0) || (mplier_nxt == '0);
`else
      last       = (cnt_nxt == '0);
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, mag_a};
                  mplier <= mag_b;
                  neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= CW'(WIDTH);
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier_nxt;
               cnt    <= cnt_nxt;
               if (last) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               {hi, lo} <= neg ? (~acc + 1'b1) : acc;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mult_unit.sv
// Randomized and directed bench for mips_mult_unit against a 64-bit product model.
// Honours MULT_EARLY_EXIT_EN when predicting latency.
module tb_mips_mult_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mips_mult_unit #(.WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .signed_op(signed_op),
      .op_a(op_a),
      .op_b(op_b),
      .busy(busy),
      .done(done),
      .hi(hi),
      .lo(lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic s);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (s) begin
         sa = 64'(signed'(a));
         sb = 64'(signed'(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Number of RUN cycles expected for this operand pair.
   function automatic int run_len(input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_EXIT_EN
      logic [31:0] mb;
      int r;
      mb = (s && b[31]) ? (32'd0 - b) : b;
      r = 1;
      for (int i = 0; i < 32; i++)
         if (mb[i]) r = i + 1;
      return r;
`else
      return (b == b) ? 32 : 32;
`endif
   endfunction

   // Launch one op and follow it cycle by cycle; optionally poke a stray
   // start mid-run or pull reset mid-run.
   task automatic run_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic s,
                         input bit poke, input bit abort);
      int r;
      int pk;
      int ak;
      logic [63:0] exp;
      r   = run_len(b, s);
      exp = model(a, b, s);
      pk  = (r >= 11) ? 9 : 1;
      ak  = (r > 5) ? 5 : 1;
      @(negedge clk);
      start = 1'b1;
      op_a = a;
      op_b = b;
      signed_op = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
      signed_op = 1'($urandom);
      chk({tag, ".busy0"}, {63'b0, busy}, 64'd1);
      for (int k = 1; k <= r + 2; k++) begin
         @(posedge clk);
         #1;
         if (abort && k == ak) begin
            rst = 1'b0;
            #1;
            chk({tag, ".rst_busy"}, {63'b0, busy}, 64'd0);
            chk({tag, ".rst_done"}, {63'b0, done}, 64'd0);
            chk({tag, ".rst_hilo"}, {hi, lo}, 64'd0);
            @(negedge clk);
            rst = 1'b1;
            for (int j = 0; j < 40; j++) begin
               @(posedge clk);
               #1;
               chk({tag, ".no_done"}, {62'b0, busy, done}, 64'd0);
            end
            return;
         end
         if (poke && k == pk) begin
            start = 1'b1;
            op_a = 32'd7;
            op_b = 32'd7;
            signed_op = 1'b0;
         end
         if (poke && k == pk + 1) start = 1'b0;
         chk({tag, ".busy"}, {63'b0, busy}, {63'b0, (k < r)});
         chk({tag, ".done"}, {63'b0, done}, {63'b0, (k == r + 1)});
         if (k >= r + 1) chk({tag, ".hilo"}, {hi, lo}, exp);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      #12;
      chk("reset.busy", {63'b0, busy}, 64'd0);
      chk("reset.done", {63'b0, done}, 64'd0);
      chk("reset.hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("t1.u3x5", 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
      chk("t1.lo", {32'b0, lo}, 64'h0000_000F);
      run_op("t2.neg", 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
      chk("t2.abs", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op("t3.umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      chk("t3.uabs", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("t3.smax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      chk("t3.sabs", {hi, lo}, 64'h0000_0000_0000_0001);
      run_op("t4.smin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      chk("t4.abs", {hi, lo}, 64'h4000_0000_0000_0000);
      run_op("t5.poke", 32'd3, 32'd5, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         #1;
         chk("t5.idle", {62'b0, busy, done}, 64'd0);
      end
      run_op("t5.7x7", 32'd7, 32'd7, 1'b0, 1'b0, 1'b0);
      chk("t5.lo", {32'b0, lo}, 64'h31);
      run_op("t6.abort", 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
      run_op("t7.b1", 32'h1234_5678, 32'd1, 1'b1, 1'b0, 1'b0);
      run_op("t7.b0", 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 20; n++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_op("rand", ra, rb, 1'($urandom), 1'b0, 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_mult_unit.md
Name: mips_mult_unit

Overview:
Multi-cycle shift-add multiplier that consumes the multiply decode from the MIPS control unit and the two register-file read operands (rs, rt). It produces a 2*WIDTH-bit product in HI/LO registers for the later MFHI/MFLO datapath. Supports signed (MULT) and unsigned (MULTU) operation through a start/busy/done handshake, so the core can stall while a multiply is in progress.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; iteration count is WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request a multiply; sampled only in IDLE.
signed_op  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
op_a  input  WIDTH  multiplicand (ReadData1/rs); sampled with start.
op_b  input  WIDTH  multiplier (ReadData2/rt); sampled with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when HI/LO are updated.
hi  output  WIDTH  upper half of the last completed product.
lo  output  WIDTH  lower half of the last completed product.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulator, operand registers and counter cleared. Reset mid-RUN aborts the operation with no HI/LO update.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1 at a clock edge:
  - Latch the magnitudes |op_a| and |op_b| as WIDTH-bit unsigned values. Magnitude is taken only when signed_op=1 and the operand MSB=1; 0x80000000 has magnitude 0x80000000.
  - Latch neg = signed_op & (op_a[MSB] ^ op_b[MSB]).
  - Clear the 2*WIDTH accumulator, load counter=WIDTH, go to RUN.
  - start=0 in IDLE: stay in IDLE.
- RUN, each cycle:
  - If multiplier LSB=1, accumulator += multiplicand (2*WIDTH-bit add, no overflow possible).
  - Multiplicand shifts left 1, multiplier shifts right 1, counter decrements.
  - When the counter reaches 0 after the update, go to DONE.
  - busy=1 throughout RUN.
- DONE (exactly one cycle):
  - {hi,lo} <= neg ? two's-complement negation of the accumulator : accumulator.
  - done=1 and busy=0 in this cycle; next state is IDLE.
- Latency: start sampled at edge N; busy high for edges N+1..N+WIDTH; done high in the cycle after edge N+WIDTH+1 and hi/lo valid from that same edge. For WIDTH=32, done is seen 33 cycles after the start edge.
- start in RUN or DONE is ignored; there is no queueing. Operand inputs may change freely after the start edge.
- hi/lo hold their value between operations and change only on entry to DONE.
- done is registered and never asserted together with busy.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: RUN also exits to DONE as soon as the shifted multiplier register is zero after an update, so the minimum RUN length is 1 cycle. Latency varies with the highest set bit of |op_b|; op_b=0 gives a 1-cycle RUN.
- Undefined: RUN always lasts exactly WIDTH cycles, giving fixed latency. Results are identical in both builds.

Test Plan:
1. Unsigned basic: signed_op=0, op_a=3, op_b=5, start 1 cycle -> busy for 32 cycles, done pulse 1 cycle, hi=0x00000000, lo=0x0000000F.
2. Signed negative: signed_op=1, op_a=0xFFFFFFFE (-2), op_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
3. Unsigned max: signed_op=0, op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with signed_op=1 -> hi=0, lo=1.
4. Signed min corner: signed_op=1, op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
5. Start while busy: start 3*5, then assert start with 7*7 at cycle 10 -> ignored, result lo=15. Issue 7*7 after done -> lo=0x31.
6. Reset mid-run: start 3*5 after a prior result lo=0x31, drive rst=0 at cycle 5 -> busy=0, done=0, hi=lo=0 immediately (asynchronous), no done pulse after release. With MULT_EARLY_EXIT_EN defined, op_b=1 -> done 2 cycles after the start edge.
